// File: rtl/sha256_msg_padder_if.sv
// Stream-in and block-out signals between the message source, the padder and the update core.
// The master side is the source/core pair; the slave side is the padder.
interface sha256_msg_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic [3:0]  rd_addr;
  logic [31:0] rd_word;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_ack;

  modport master (
    output in_valid, in_data, in_last, in_bytes, rd_addr, blk_ack,
    input  in_ready, rd_word, blk_valid, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, rd_addr, blk_ack,
    output in_ready, rd_word, blk_valid, blk_last
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a big-endian word stream into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit bit length, and hands each block to the core via valid/ack.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  sha256_msg_padder_if.slave   bus,
  output logic                 msg_done,
  output logic                 error
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_WAIT, S_ERROR} state_t;

  state_t             state_reg;
  logic [3:0]         widx_reg;
  logic [LEN_W-1:0]   bit_len_reg;
  logic               pad_done_reg;
  logic               pad_more_reg;
  logic               len_hi_reg;
  logic               in_ready_reg;
  logic               blk_valid_reg;
  logic               blk_last_reg;
  logic               msg_done_reg;
  logic               error_reg;

  logic               beat_fire;
  logic               beat_bad;
  logic               len_ovf;
  logic [2:0]         beat_n;
  logic [LEN_W:0]     len_sum;
  logic [63:0]        len64;
  logic [31:0]        beat_word;
  logic               wr_en;
  logic               clr_en;
  logic [31:0]        wr_data;
  logic [511:0]       words_flat;

  assign beat_fire = bus.in_valid && in_ready_reg && (state_reg == S_FILL);
  assign beat_n    = bus.in_last ? bus.in_bytes : 3'd4;
  assign beat_bad  = bus.in_last && (bus.in_bytes > 3'd4);
  assign len_sum   = {1'b0, bit_len_reg} + (LEN_W+1)'({beat_n, 3'b000});
  assign len_ovf   = len_sum[LEN_W];
  assign len64     = 64'(bit_len_reg);

  // A short final beat keeps its valid bytes, gets 0x80 right after them and zeros beyond.
  always_comb begin
    beat_word = bus.in_data;
    if (bus.in_last) begin
      case (bus.in_bytes)
        3'd0:    beat_word = 32'h8000_0000;
        3'd1:    beat_word = {bus.in_data[31:24], 24'h80_0000};
        3'd2:    beat_word = {bus.in_data[31:16], 16'h8000};
        3'd3:    beat_word = {bus.in_data[31:8], 8'h80};
        default: beat_word = bus.in_data;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    wr_data = 32'h0;
    case (state_reg)
      S_FILL: begin
        if (beat_fire && !beat_bad && !len_ovf) begin
          wr_en   = 1'b1;
          wr_data = beat_word;
        end
      end
      S_PAD: begin
        wr_en = 1'b1;
        if (widx_reg == 4'd14 && pad_done_reg)
          wr_data = len64[63:32];
        else if (widx_reg == 4'd15 && len_hi_reg)
          wr_data = len64[31:0];
        else
          wr_data = pad_done_reg ? 32'h0 : 32'h8000_0000;
      end
      S_WAIT:  clr_en = bus.blk_ack;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    logic [31:0] word_reg;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        word_reg <= 32'h0;
      else if (clr_en)
        word_reg <= 32'h0;
      else if (wr_en && widx_reg == 4'(gi))
        word_reg <= wr_data;
    end
    assign words_flat[gi*32 +: 32] = word_reg;
  end

  assign bus.rd_word   = words_flat[{bus.rd_addr, 5'b00000} +: 32];
  assign bus.in_ready  = in_ready_reg;
  assign bus.blk_valid = blk_valid_reg;
  assign bus.blk_last  = blk_last_reg;
  assign msg_done      = msg_done_reg;
  assign error         = error_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_FILL;
      widx_reg      <= 4'd0;
      bit_len_reg   <= '0;
      pad_done_reg  <= 1'b0;
      pad_more_reg  <= 1'b0;
      len_hi_reg    <= 1'b0;
      in_ready_reg  <= 1'b0;
      blk_valid_reg <= 1'b0;
      blk_last_reg  <= 1'b0;
      msg_done_reg  <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      msg_done_reg <= 1'b0;
      case (state_reg)
        S_FILL: begin
          in_ready_reg <= 1'b1;
          if (beat_fire) begin
            if (beat_bad || len_ovf) begin
              state_reg    <= S_ERROR;
              error_reg    <= 1'b1;
              in_ready_reg <= 1'b0;
            end else begin
              widx_reg    <= widx_reg + 4'd1;
              bit_len_reg <= len_sum[LEN_W-1:0];
              if (bus.in_last) begin
                pad_done_reg <= (beat_n != 3'd4);
                in_ready_reg <= 1'b0;
                // A last beat in word 15 leaves no room: length goes in a follow-up block.
                if (widx_reg == 4'd15) begin
                  state_reg     <= S_WAIT;
                  blk_valid_reg <= 1'b1;
                  blk_last_reg  <= 1'b0;
                  pad_more_reg  <= 1'b1;
                end else begin
                  state_reg <= S_PAD;
                end
              end else if (widx_reg == 4'd15) begin
                state_reg     <= S_WAIT;
                blk_valid_reg <= 1'b1;
                blk_last_reg  <= 1'b0;
                in_ready_reg  <= 1'b0;
              end
            end
          end
        end
        S_PAD: begin
          widx_reg     <= widx_reg + 4'd1;
          pad_done_reg <= 1'b1;
          if (widx_reg == 4'd14 && pad_done_reg) begin
            len_hi_reg <= 1'b1;
          end else if (widx_reg == 4'd15) begin
            state_reg     <= S_WAIT;
            blk_valid_reg <= 1'b1;
            len_hi_reg    <= 1'b0;
            blk_last_reg  <= len_hi_reg;
            pad_more_reg  <= !len_hi_reg;
          end
        end
        S_WAIT: begin
          if (bus.blk_ack) begin
            widx_reg      <= 4'd0;
            blk_valid_reg <= 1'b0;
            if (pad_more_reg) begin
              state_reg    <= S_PAD;
              pad_more_reg <= 1'b0;
            end else if (blk_last_reg) begin
              state_reg    <= S_FILL;
              in_ready_reg <= 1'b1;
              msg_done_reg <= 1'b1;
              bit_len_reg  <= '0;
              pad_done_reg <= 1'b0;
              blk_last_reg <= 1'b0;
            end else begin
              state_reg    <= S_FILL;
              in_ready_reg <= 1'b1;
            end
          end
        end
        S_ERROR: begin
          error_reg     <= 1'b1;
          in_ready_reg  <= 1'b0;
          blk_valid_reg <= 1'b0;
        end
        default: begin
          state_reg     <= S_ERROR;
          error_reg     <= 1'b1;
          in_ready_reg  <= 1'b0;
          blk_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder: a byte-level FIPS 180-4 padding model feeds a block
// scoreboard, and an independent monitor reads, compares and acknowledges each presented block.
module tb_sha256_msg_padder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic msg_done;
  logic error;

  sha256_msg_padder_if bus ();

  sha256_msg_padder #(.LEN_W(64)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .msg_done (msg_done),
    .error    (error)
  );

  always #25 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;
  int blk_cnt       = 0;

  logic [511:0] exp_words_q [$];
  bit           exp_last_q  [$];
  logic [7:0]   msg_q       [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Reference: pad the byte string exactly as the standard describes, then slice into blocks.
  task automatic build_model();
    logic [7:0]   p [$];
    logic [63:0]  len_bits;
    logic [511:0] w;
    int           nblk;
    p = msg_q;
    len_bits = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(len_bits[8*k +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      w = '0;
      for (int i = 0; i < 64; i++) w[511-8*i -: 8] = p[b*64+i];
      exp_words_q.push_back(w);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = nb;
    cnt = 0;
    while (!bus.in_ready && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    check("beat_accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_msg();
    int n, beats, nb;
    logic [31:0] d;
    n = msg_q.size();
    build_model();
    beats = (n == 0) ? 1 : (n + 3) / 4;
    for (int j = 0; j < beats; j++) begin
      for (int k = 0; k < 4; k++)
        d[31-8*k -: 8] = (4*j + k < n) ? msg_q[4*j+k] : 8'($urandom);
      if (j == beats - 1) nb = n - 4*j;
      else nb = $urandom_range(0, 7);
      send_beat(d, j == beats - 1, 3'(nb));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic fill_random(input int n);
    msg_q = {};
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_words_q.size() != 0 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_drained", 32'(exp_words_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_blk_valid"}, 32'(bus.blk_valid), 32'd0);
    check({tag, "_blk_last"},  32'(bus.blk_last),  32'd0);
    check({tag, "_msg_done"},  32'(msg_done),      32'd0);
    check({tag, "_error"},     32'(error),         32'd0);
    for (int i = 0; i < 16; i += 5) begin
      bus.rd_addr = 4'(i);
      #1;
      check($sformatf("%s_w%0d", tag, i), bus.rd_word, 32'h0);
    end
  endtask

  // Monitor: compare each presented block against the scoreboard, then ack after a random wait.
  initial begin
    logic [511:0] ew;
    bit           el;
    int           a;
    forever begin
      @(negedge clk);
      if (reset && bus.blk_valid) begin
        check("blk_expected", 32'(exp_words_q.size() != 0), 32'd1);
        if (exp_words_q.size() != 0) begin
          ew = exp_words_q.pop_front();
          el = exp_last_q.pop_front();
          for (int i = 0; i < 16; i++) begin
            bus.rd_addr = 4'(i);
            #1;
            check($sformatf("blk%0d_w%0d", blk_cnt, i), bus.rd_word, ew[511-32*i -: 32]);
          end
          check($sformatf("blk%0d_last", blk_cnt), 32'(bus.blk_last), 32'(el));
          repeat ($urandom_range(0, 4)) begin
            @(negedge clk);
            check("wait_blk_valid", 32'(bus.blk_valid), 32'd1);
            check("wait_in_ready",  32'(bus.in_ready),  32'd0);
            a = $urandom_range(0, 15);
            bus.rd_addr = 4'(a);
            #1;
            check($sformatf("blk%0d_stable_w%0d", blk_cnt, a), bus.rd_word, ew[511-32*a -: 32]);
          end
          bus.blk_ack = 1'b1;
          @(negedge clk);
          bus.blk_ack = 1'b0;
          check($sformatf("blk%0d_msg_done", blk_cnt), 32'(msg_done), 32'(el));
          check("blk_valid_after_ack", 32'(bus.blk_valid), 32'd0);
          $display("block %0d checked last=%0d", blk_cnt, el);
          blk_cnt++;
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.in_bytes = 3'd0;
    bus.rd_addr  = 4'd0;
    bus.blk_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("in_ready_after_release", 32'(bus.in_ready), 32'd1);

    msg_q = {8'h61, 8'h62, 8'h63};
    send_msg();
    msg_q = {};
    send_msg();
    fill_random(56);
    send_msg();
    fill_random(64);
    send_msg();
    msg_q = {8'h61, 8'h62, 8'h63};
    send_msg();
    for (int t = 0; t < 20; t++) begin
      fill_random($urandom_range(0, 130));
      send_msg();
    end
    wait_drain();

    // Illegal byte count on a last beat makes the block stick in error.
    send_beat($urandom, 1'b1, 3'($urandom_range(5, 7)));
    check("error_set",      32'(error),        32'd1);
    check("error_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("error_sticky",    32'(error),         32'd1);
      check("error_no_ready",  32'(bus.in_ready),  32'd0);
      check("error_no_blk",    32'(bus.blk_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    #5 reset = 1'b0;
    #1 check_reset_vals("reset_from_error");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    send_beat(32'h6162_6300, 1'b1, 3'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check_reset_vals("reset_mid_pad");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    msg_q = {8'h61, 8'h62, 8'h63};
    send_msg();
    wait_drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
